// File: rtl/mem_access_sequencer_if.sv
// Bundle of the core-side request/response signals and the memory-side
// request/ack signals of the load/store sequencer.
//
// Handshake rules (valid/ready):
//   req_valid/req_ready: a request transfers on a rising edge where both are 1.
//     The core keeps the request fields stable until it sees rsp_valid.
//   rsp_valid: one-cycle strobe; rsp_rdata and rsp_fault are meaningful
//     only while it is 1.
//   mem_req/mem_ack: the memory completes on a rising edge where both are 1;
//     mem_we, mem_addr, mem_be and mem_wdata stay stable while mem_req is 1.
interface mem_access_sequencer_if;
  logic        req_valid;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_b_e;
  logic        req_h_e;
  logic        req_w_e;
  logic        req_unsigned;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Core and memory side together: drives requests and memory completions.
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_b_e, req_h_e, req_w_e,
           req_unsigned, mem_ack, mem_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_fault,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // The sequencer itself.
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_b_e, req_h_e, req_w_e,
           req_unsigned, mem_ack, mem_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_fault,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: accepts one core request, checks size/alignment,
// runs a single memory access with a timeout, and returns extended load data.
module mem_access_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_sequencer_if.slave bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               wr_q;
  logic               b_q;
  logic               h_q;
  logic               w_q;
  logic               uns_q;
  logic [CNT_W-1:0]   cnt;

  logic               legal;
  logic [3:0]         be_lat;
  logic [31:0]        wdata_lat;
  logic [31:0]        shifted;
  logic [31:0]        load_data;
  logic [CNT_W-1:0]   cnt_inc;

  // Request legality: exactly one size select and natural alignment.
  always_comb begin
    legal = 1'b0;
    case ({bus.req_b_e, bus.req_h_e, bus.req_w_e})
      3'b100:  legal = 1'b1;
      3'b010:  legal = ~bus.req_addr[0];
      3'b001:  legal = (bus.req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Byte strobes and lane-replicated store data, from latched fields only.
  always_comb begin
    be_lat    = 4'b0000;
    wdata_lat = wdata_q;
    if (b_q) begin
      be_lat    = 4'b0001 << addr_q[1:0];
      wdata_lat = {4{wdata_q[7:0]}};
    end else if (h_q) begin
      be_lat    = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_lat = {2{wdata_q[15:0]}};
    end else if (w_q) begin
      be_lat    = 4'b1111;
      wdata_lat = wdata_q;
    end
  end

  // Align the addressed lane of the memory word to bit 0, then extend.
  always_comb begin
    shifted   = bus.mem_rdata;
    load_data = bus.mem_rdata;
    if (b_q) begin
      shifted   = bus.mem_rdata >> {addr_q[1:0], 3'b000};
      load_data = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end else if (h_q) begin
      shifted   = bus.mem_rdata >> {addr_q[1], 4'b0000};
      load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end
    if (wr_q) begin
      load_data = 32'h0;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  // Memory-side outputs decode straight from state so a reset drops them at once.
  assign bus.mem_req   = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) & wr_q;
  assign bus.mem_be    = (state == ACCESS) ? be_lat : 4'b0000;
  assign bus.mem_wdata = wdata_lat;
  assign bus.mem_addr  = addr_q[31:2];
  assign bus.req_ready = (state == IDLE);
  assign bus.stall     = ~rst & (((state == IDLE) & bus.req_valid) | (state == ACCESS));
  assign dbg_state     = state;

  // Sequencer FSM: request latch, timeout counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      wr_q          <= 1'b0;
      b_q           <= 1'b0;
      h_q           <= 1'b0;
      w_q           <= 1'b0;
      uns_q         <= 1'b0;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_fault <= 1'b0;
      bus.rsp_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wr_q    <= bus.req_wr;
            b_q     <= bus.req_b_e;
            h_q     <= bus.req_h_e;
            w_q     <= bus.req_w_e;
            uns_q   <= bus.req_unsigned;
            cnt     <= '0;
            if (legal) begin
              state <= ACCESS;
            end else begin
              // Illegal size/alignment never reaches memory.
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_fault <= 1'b1;
              bus.rsp_rdata <= 32'h0;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            // A completion on the timeout cycle still counts as success.
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= 1'b0;
            bus.rsp_rdata <= load_data;
          end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state         <= RESP;
            cnt           <= cnt_inc;
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= 1'b1;
            bus.rsp_rdata <= 32'h0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_fault <= 1'b0;
          bus.rsp_rdata <= 32'h0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a short timeout.
module tb_mem_access_sequencer;

  localparam int TB_TIMEOUT = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mem_access_sequencer_if bus ();

  mem_access_sequencer #(
    .TIMEOUT (TB_TIMEOUT),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wr;
    logic        b;
    logic        h;
    logic        w;
    logic        uns;
    int          waits;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        fault;
    logic [31:0] rsp;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_miss;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid    = 1'b0;
    bus.req_wr       = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_b_e      = 1'b0;
    bus.req_h_e      = 1'b0;
    bus.req_w_e      = 1'b0;
    bus.req_unsigned = 1'b0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = 32'h0;
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid    = 1'b1;
    bus.req_wr       = v.wr;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_b_e      = v.b;
    bus.req_h_e      = v.h;
    bus.req_w_e      = v.w;
    bus.req_unsigned = v.uns;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = v.rdata;
  endtask

  // One transaction, entered and left at a falling edge with the FSM idle.
  task automatic run_vec(input vec_t v);
    int n_acc;
    drive_req(v);
    #1;
    chk("idle_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("idle_stall", {31'h0, bus.stall}, 32'h1);
    exp_q.push_back(v.rsp);
    @(posedge clk);
    @(negedge clk);
    if (v.legal) begin
      n_acc = (v.waits < TB_TIMEOUT) ? v.waits + 1 : TB_TIMEOUT;
      for (int k = 0; k < n_acc; k++) begin
        chk("acc_mem_req", {31'h0, bus.mem_req}, 32'h1);
        chk("acc_mem_we", {31'h0, bus.mem_we}, {31'h0, v.wr});
        chk("acc_mem_addr", {2'b00, bus.mem_addr}, {2'b00, v.addr[31:2]});
        chk("acc_mem_be", {28'h0, bus.mem_be}, {28'h0, v.be});
        chk("acc_mem_wdata", bus.mem_wdata, v.mwdata);
        chk("acc_stall", {31'h0, bus.stall}, 32'h1);
        chk("acc_req_ready", {31'h0, bus.req_ready}, 32'h0);
        chk("acc_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        bus.mem_ack = (k == v.waits);
        @(posedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b0;
      end
    end
    chk("rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("rsp_fault", {31'h0, bus.rsp_fault}, {31'h0, v.fault});
    chk("rsp_rdata", bus.rsp_rdata, exp_q.pop_front());
    chk("rsp_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rsp_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rsp_mem_be", {28'h0, bus.mem_be}, 32'h0);
    chk("rsp_stall", {31'h0, bus.stall}, 32'h0);
    chk("rsp_req_ready", {31'h0, bus.req_ready}, 32'h0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("post_req_ready", {31'h0, bus.req_ready}, 32'h1);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    // addr, wdata, rdata, wr, b, h, w, uns, waits, legal, be, mwdata, fault, rsp
    vecs[0]  = '{32'h0000_1003, 32'h0,         32'h80FF_1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 4'b1000, 32'h0,         1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{32'h0000_2002, 32'hDEAD_BEEF, 32'h1111_2222, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0};
    vecs[2]  = '{32'h0000_0006, 32'h0,         32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{32'h0000_0002, 32'h0,         32'hF00D_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 4'b1100, 32'h0,         1'b0, 32'h0000_F00D};
    vecs[4]  = '{32'h0000_0010, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 4'b1111, 32'h0,         1'b0, 32'h1234_5678};
    vecs[5]  = '{32'h0000_0021, 32'h0,         32'h0000_AB00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 4'b0010, 32'h0,         1'b0, 32'h0000_00AB};
    vecs[6]  = '{32'h0000_0040, 32'h0,         32'h1234_8001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 4'b0011, 32'h0,         1'b0, 32'hFFFF_8001};
    vecs[7]  = '{32'h0000_0102, 32'h0000_00A5, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 4'b0100, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[8]  = '{32'h0000_0030, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9, 1'b1, 4'b1111, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{32'h0000_0008, 32'hCAFE_F00D, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[10] = '{32'h0000_0034, 32'h0,         32'h7777_7777, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9, 1'b1, 4'b1111, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{32'h0000_0001, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[12] = '{32'h0000_0000, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{32'h0000_0000, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0};

    // Reset state, with a request already pending on the bus.
    drive_idle();
    rst = 1'b1;
    bus.req_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_stall", {31'h0, bus.stall}, 32'h0);
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i]);
    end

    // Reset pulsed between edges in the second ACCESS cycle of a waiting load.
    drive_req(vecs[4]);
    @(posedge clk);
    @(negedge clk);
    chk("abort_c1_mem_req", {31'h0, bus.mem_req}, 32'h1);
    @(posedge clk);
    #2;
    chk("abort_c2_mem_req", {31'h0, bus.mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    bus.req_valid = 1'b0;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      chk("abort_no_mem_req", {31'h0, bus.mem_req}, 32'h0);
    end
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
